// File: rtl/dlx_pkg.sv
// dlx_pkg: shared constants for the pipelined DLX core.
//   DATA_W / REG_AW / FUNC_W : datapath, register-index and ALU func widths
//   FUNC_*                   : alu32 func codes (R-type funct field encoding)
package dlx_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int FUNC_W = 6;

   localparam logic [FUNC_W-1:0] FUNC_NOP = 6'b000000;
   localparam logic [FUNC_W-1:0] FUNC_ADD = 6'b100000;
   localparam logic [FUNC_W-1:0] FUNC_SUB = 6'b100010;
   localparam logic [FUNC_W-1:0] FUNC_AND = 6'b100100;
   localparam logic [FUNC_W-1:0] FUNC_OR  = 6'b100101;
   localparam logic [FUNC_W-1:0] FUNC_XOR = 6'b100110;
   localparam logic [FUNC_W-1:0] FUNC_SLT = 6'b101010;

endpackage

// File: rtl/dlx_id_ex_stage_if.sv
// dlx_id_ex_stage_if: signal bundle around the ID/EX pipeline register.
//   id_*      : decoded instruction from ID
//   exm_*     : EX/MEM forwarding source
//   wb_*      : MEM/WB forwarding source
//   ex_hold   : downstream stall, flush : taken-branch squash
//   stall_id, ex_*, stall_cnt : stage outputs toward IF/ID and alu32
// master = surrounding pipeline, slave = the ID/EX stage.
interface dlx_id_ex_stage_if #(
   parameter int DATA_W = dlx_pkg::DATA_W,
   parameter int REG_AW = dlx_pkg::REG_AW,
   parameter int FUNC_W = dlx_pkg::FUNC_W
);

   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;
   logic [DATA_W-1:0] id_rf_d1;
   logic [DATA_W-1:0] id_rf_d2;
   logic [DATA_W-1:0] id_imm;
   logic              id_use_imm;
   logic [FUNC_W-1:0] id_func;
   logic              id_reg_write;
   logic              id_is_load;

   logic              exm_valid;
   logic              exm_reg_write;
   logic [REG_AW-1:0] exm_rd;
   logic [DATA_W-1:0] exm_result;

   logic              wb_valid;
   logic              wb_reg_write;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;

   logic              ex_hold;
   logic              flush;

   logic              stall_id;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_d1;
   logic [DATA_W-1:0] ex_d2;
   logic [DATA_W-1:0] ex_store_data;
   logic [FUNC_W-1:0] ex_func;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write;
   logic              ex_is_load;
   logic [31:0]       stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_rf_d1, id_rf_d2, id_imm,
             id_use_imm, id_func, id_reg_write, id_is_load,
             exm_valid, exm_reg_write, exm_rd, exm_result,
             wb_valid, wb_reg_write, wb_rd, wb_data, ex_hold, flush,
      input  stall_id, ex_valid, ex_d1, ex_d2, ex_store_data, ex_func,
             ex_rd, ex_reg_write, ex_is_load, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_rf_d1, id_rf_d2, id_imm,
             id_use_imm, id_func, id_reg_write, id_is_load,
             exm_valid, exm_reg_write, exm_rd, exm_result,
             wb_valid, wb_reg_write, wb_rd, wb_data, ex_hold, flush,
      output stall_id, ex_valid, ex_d1, ex_d2, ex_store_data, ex_func,
             ex_rd, ex_reg_write, ex_is_load, stall_cnt
   );

endinterface

// File: rtl/dlx_fwd_mux.sv
// dlx_fwd_mux: forwarding select for one source operand.
//   rs / rf_val          : captured source index and register-file value
//   exm_* / wb_*         : EX/MEM and MEM/WB writeback candidates
//   val                  : resolved operand
// EX/MEM is younger than MEM/WB, so it wins when both target rs.
// r0 never forwards: its captured RF value (0) is used.
module dlx_fwd_mux #(
   parameter int DATA_W = dlx_pkg::DATA_W,
   parameter int REG_AW = dlx_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [DATA_W-1:0] rf_val,
   input  logic              exm_valid,
   input  logic              exm_reg_write,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              wb_valid,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] val
);

   logic exm_hit, wb_hit;

   assign exm_hit = exm_valid & exm_reg_write & (exm_rd != '0) & (exm_rd == rs);
   assign wb_hit  = wb_valid  & wb_reg_write  & (wb_rd  != '0) & (wb_rd  == rs);

   assign val = exm_hit ? exm_result :
                wb_hit  ? wb_data    : rf_val;

endmodule

// File: rtl/dlx_id_ex_stage.sv
// dlx_id_ex_stage: ID/EX pipeline register with EX-side operand forwarding.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dlx_id_ex_stage_if.slave (ID inputs, EX/MEM + MEM/WB
//                forwarding sources, hold/flush, EX outputs to alu32)
// Update priority each edge: reset > flush > ex_hold > load-use bubble > capture.
// ex_d1/ex_d2/ex_store_data are combinational on the registered operands so
// they follow exm_*/wb_* every cycle, including while held.
module dlx_id_ex_stage import dlx_pkg::*; #(
   parameter int DATA_W = dlx_pkg::DATA_W,
   parameter int REG_AW = dlx_pkg::REG_AW,
   parameter int FUNC_W = dlx_pkg::FUNC_W
) (
   input logic              clk,
   input logic              rst_n,
   dlx_id_ex_stage_if.slave bus
);

   localparam int NUM_OPS = 2;   // [0] = rs1, [1] = rs2

   logic                           ex_valid_q, ex_reg_write_q, ex_is_load_q, ex_use_imm_q;
   logic [REG_AW-1:0]              ex_rd_q;
   logic [FUNC_W-1:0]              ex_func_q;
   logic [DATA_W-1:0]              ex_imm_q;
   logic [NUM_OPS-1:0][REG_AW-1:0] ex_rs_q, id_rs;
   logic [NUM_OPS-1:0][DATA_W-1:0] ex_rf_q, id_rf, fwd_val;
   logic [31:0]                    stall_cnt_q;
   logic                           load_use;

   assign id_rs = {bus.id_rs2, bus.id_rs1};
   assign id_rf = {bus.id_rf_d2, bus.id_rf_d1};

   // A load in EX cannot feed ID's consumer through EX/MEM; an immediate-form
   // instruction does not read rs2, so only rs1 counts there.
   assign load_use = ex_valid_q & ex_is_load_q & ex_reg_write_q & (ex_rd_q != '0) &
                     bus.id_valid &
                     ((bus.id_rs1 == ex_rd_q) | ((bus.id_rs2 == ex_rd_q) & ~bus.id_use_imm));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_q     <= 1'b0;
         ex_reg_write_q <= 1'b0;
         ex_is_load_q   <= 1'b0;
         ex_use_imm_q   <= 1'b0;
         ex_rd_q        <= '0;
         ex_func_q      <= FUNC_NOP;
         ex_imm_q       <= '0;
         ex_rs_q        <= '0;
         ex_rf_q        <= '0;
         stall_cnt_q    <= '0;
      end else if (bus.flush) begin
         // Squash only; payload fields are dead once valid drops.
         ex_valid_q     <= 1'b0;
         ex_reg_write_q <= 1'b0;
         ex_is_load_q   <= 1'b0;
      end else if (bus.ex_hold) begin
         // freeze everything
      end else if (load_use) begin
         ex_valid_q     <= 1'b0;
         ex_reg_write_q <= 1'b0;
         ex_is_load_q   <= 1'b0;
         if (stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
         ex_valid_q     <= bus.id_valid;
         ex_reg_write_q <= bus.id_reg_write;
         ex_is_load_q   <= bus.id_is_load;
         ex_use_imm_q   <= bus.id_use_imm;
         ex_rd_q        <= bus.id_rd;
         ex_func_q      <= bus.id_func;
         ex_imm_q       <= bus.id_imm;
         ex_rs_q        <= id_rs;
         ex_rf_q        <= id_rf;
      end
   end

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
      dlx_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
         .rs            (ex_rs_q[g]),
         .rf_val        (ex_rf_q[g]),
         .exm_valid     (bus.exm_valid),
         .exm_reg_write (bus.exm_reg_write),
         .exm_rd        (bus.exm_rd),
         .exm_result    (bus.exm_result),
         .wb_valid      (bus.wb_valid),
         .wb_reg_write  (bus.wb_reg_write),
         .wb_rd         (bus.wb_rd),
         .wb_data       (bus.wb_data),
         .val           (fwd_val[g])
      );
   end

   assign bus.stall_id      = bus.ex_hold | load_use;
   assign bus.ex_valid      = ex_valid_q;
   assign bus.ex_d1         = fwd_val[0];
   assign bus.ex_d2         = ex_use_imm_q ? ex_imm_q : fwd_val[1];
   assign bus.ex_store_data = fwd_val[1];
   assign bus.ex_func       = ex_func_q;
   assign bus.ex_rd         = ex_rd_q;
   assign bus.ex_reg_write  = ex_reg_write_q;
   assign bus.ex_is_load    = ex_is_load_q;
   assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_dlx_id_ex_stage.sv
// tb_dlx_id_ex_stage: directed scenarios plus randomized traffic, checked
// against an instruction-level model of what occupies the EX slot.
module tb_dlx_id_ex_stage;
   import dlx_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dlx_id_ex_stage_if bus ();

   dlx_id_ex_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Model: the instruction sitting in EX, as ID presented it.
   typedef struct {
      bit        valid, rw, ld, use_imm;
      bit [4:0]  rs1, rs2, rd;
      bit [31:0] rf1, rf2, imm;
      bit [5:0]  func;
   } instr_t;

   instr_t    m;
   bit        known;       // payload fields meaningful (not after squash)
   bit [31:0] cnt;
   int        n_chk = 0;
   int        n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Value the consumer must see for source register rs.
   function automatic bit [31:0] opnd(input bit [4:0] rs, input bit [31:0] rfv);
      if (rs == 0) return rfv;
      if (bus.exm_valid && bus.exm_reg_write && bus.exm_rd == rs) return bus.exm_result;
      if (bus.wb_valid && bus.wb_reg_write && bus.wb_rd == rs) return bus.wb_data;
      return rfv;
   endfunction

   function automatic bit dep_on_load();
      bit reads_rd;
      reads_rd = (bus.id_rs1 == m.rd) || (!bus.id_use_imm && bus.id_rs2 == m.rd);
      return m.valid && m.ld && m.rw && m.rd != 0 && bus.id_valid && reads_rd;
   endfunction

   task automatic settle_check();
      #1;
      chk("stall_id", bus.stall_id, bus.ex_hold | dep_on_load());
      chk("ex_valid", bus.ex_valid, m.valid);
      chk("ex_reg_write", bus.ex_reg_write, m.rw);
      chk("ex_is_load", bus.ex_is_load, m.ld);
      chk("stall_cnt", bus.stall_cnt, cnt);
      if (known) begin
         chk("ex_d1", bus.ex_d1, opnd(m.rs1, m.rf1));
         chk("ex_d2", bus.ex_d2, m.use_imm ? m.imm : opnd(m.rs2, m.rf2));
         chk("ex_store_data", bus.ex_store_data, opnd(m.rs2, m.rf2));
         chk("ex_func", 32'(bus.ex_func), 32'(m.func));
         chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
      end
   endtask

   task automatic advance();
      instr_t    nm;
      bit        nk;
      bit [31:0] nc;
      nm = m; nk = known; nc = cnt;
      if (!rst_n) begin
         nm = '{default: 0};
         nk = 1; nc = 0;
      end else if (bus.flush) begin
         nm.valid = 0; nm.rw = 0; nm.ld = 0; nk = 0;
      end else if (bus.ex_hold) begin
         // unchanged
      end else if (dep_on_load()) begin
         nm.valid = 0; nm.rw = 0; nm.ld = 0; nk = 0;
         if (nc != 32'hFFFF_FFFF) nc = nc + 1;
      end else begin
         nm.valid = bus.id_valid;   nm.rw = bus.id_reg_write; nm.ld = bus.id_is_load;
         nm.use_imm = bus.id_use_imm;
         nm.rs1 = bus.id_rs1; nm.rs2 = bus.id_rs2; nm.rd = bus.id_rd;
         nm.rf1 = bus.id_rf_d1; nm.rf2 = bus.id_rf_d2; nm.imm = bus.id_imm;
         nm.func = bus.id_func; nk = 1;
      end
      @(posedge clk);
      m = nm; known = nk; cnt = nc;
      @(negedge clk);
   endtask

   task automatic set_id(input bit v, input bit [4:0] rs1, rs2, rd, input bit [31:0] rf1, rf2, imm,
                         input bit use_imm, input bit [5:0] func, input bit rw, ld);
      bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
      bus.id_rf_d1 = rf1; bus.id_rf_d2 = rf2; bus.id_imm = imm; bus.id_use_imm = use_imm;
      bus.id_func = func; bus.id_reg_write = rw; bus.id_is_load = ld;
   endtask

   task automatic set_exm(input bit v, rw, input bit [4:0] rd, input bit [31:0] res);
      bus.exm_valid = v; bus.exm_reg_write = rw; bus.exm_rd = rd; bus.exm_result = res;
   endtask

   task automatic set_wb(input bit v, rw, input bit [4:0] rd, input bit [31:0] d);
      bus.wb_valid = v; bus.wb_reg_write = rw; bus.wb_rd = rd; bus.wb_data = d;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, FUNC_NOP, 0, 0);
      set_exm(0, 0, 0, 0);
      set_wb(0, 0, 0, 0);
      bus.ex_hold = 0; bus.flush = 0;
   endtask

   initial begin
      m = '{default: 0}; known = 0; cnt = 0;
      idle();
      rst_n = 0;
      advance();                      // reset edge
      rst_n = 1;

      // reset state
      settle_check();
      chk("rst_ex_valid", bus.ex_valid, 0);
      chk("rst_stall_id", bus.stall_id, 0);
      chk("rst_stall_cnt", bus.stall_cnt, 0);
      chk("rst_reg_write", bus.ex_reg_write, 0);
      chk("rst_ex_d1", bus.ex_d1, 0);
      advance();

      // EX/MEM over MEM/WB, then MEM/WB alone
      set_id(1, 3, 4, 7, 32'h1111_1111, 32'h2222_2222, 0, 0, FUNC_ADD, 1, 0);
      settle_check(); advance();
      idle();
      set_exm(1, 1, 3, 32'h1234_5678);
      set_wb(1, 1, 3, 32'hDEAD_0000);
      settle_check();
      chk("exm_priority", bus.ex_d1, 32'h1234_5678);
      bus.exm_valid = 0;
      settle_check();
      chk("wb_forward", bus.ex_d1, 32'hDEAD_0000);
      advance();

      // r0 guard
      idle();
      set_id(1, 1, 0, 2, 32'h5, 0, 0, 0, FUNC_ADD, 1, 0);
      settle_check(); advance();
      idle();
      set_exm(1, 1, 0, 32'hFFFF_FFFF);
      set_wb(1, 1, 0, 32'hFFFF_FFFF);
      settle_check();
      chk("r0_d2", bus.ex_d2, 0);
      chk("r0_store", bus.ex_store_data, 0);
      advance();

      // load-use on rs1: bubble, then MEM/WB supplies the loaded value
      idle();
      set_id(1, 1, 2, 5, 0, 0, 0, 0, FUNC_ADD, 1, 1);
      settle_check(); advance();
      set_id(1, 5, 6, 8, 32'h0000_0BAD, 32'h6, 0, 0, FUNC_SUB, 1, 0);
      settle_check();
      chk("lu_stall", bus.stall_id, 1);
      advance();
      set_exm(1, 1, 5, 32'h0BAD_BEEF);
      settle_check();
      chk("lu_bubble", bus.ex_valid, 0);
      chk("lu_cnt", bus.stall_cnt, 1);
      chk("lu_release", bus.stall_id, 0);
      advance();
      idle();
      set_wb(1, 1, 5, 32'hCAFE_F00D);
      settle_check();
      chk("lu_valid", bus.ex_valid, 1);
      chk("lu_wb_d1", bus.ex_d1, 32'hCAFE_F00D);
      advance();

      // immediate path: rs2 match against a load does not stall
      idle();
      set_id(1, 1, 1, 9, 0, 0, 0, 0, FUNC_ADD, 1, 1);
      settle_check(); advance();
      set_id(1, 1, 9, 10, 32'h1, 32'h33, 32'h10, 1, FUNC_ADD, 1, 0);
      settle_check();
      chk("imm_no_stall", bus.stall_id, 0);
      advance();
      idle();
      set_exm(1, 1, 9, 32'h7777_7777);
      settle_check();
      chk("imm_d2", bus.ex_d2, 32'h10);
      chk("imm_store", bus.ex_store_data, 32'h7777_7777);
      chk("imm_cnt", bus.stall_cnt, 1);
      advance();

      // flush beats hold
      idle();
      set_id(1, 2, 3, 4, 1, 2, 0, 0, FUNC_OR, 1, 0);
      settle_check(); advance();
      idle();
      bus.flush = 1; bus.ex_hold = 1;
      settle_check(); advance();
      idle();
      settle_check();
      chk("flush_over_hold", bus.ex_valid, 0);

      // hold freezes for 3 cycles while ID keeps changing
      set_id(1, 2, 3, 4, 1, 2, 0, 0, FUNC_SUB, 1, 0);
      advance();
      for (int i = 0; i < 3; i++) begin
         set_id(1, 5'(i + 6), 0, 5'(i + 11), 32'(i), 0, 0, 0, FUNC_XOR, 0, 1);
         bus.ex_hold = 1;
         settle_check();
         chk("hold_valid", bus.ex_valid, 1);
         chk("hold_rd", 32'(bus.ex_rd), 4);
         chk("hold_func", 32'(bus.ex_func), 32'(FUNC_SUB));
         advance();
      end

      // randomized traffic, small index range to force hits
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom),
                6'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
         set_exm(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
         set_wb(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
         bus.ex_hold = ($urandom_range(0, 5) == 0);
         bus.flush   = ($urandom_range(0, 7) == 0);
         settle_check();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
